// File: rtl/center_scale_mc.sv
// Multi-channel center/scale stage: z = (x - mean[ch]) * inv_std[ch], 3-stage pipeline,
// per-channel runtime coefficients and mode, sticky saturation / bad-channel flags.

module center_scale_mc_coef #(
  parameter int ADC_W     = 21,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADC_W-1:0]  mean_i,
  input  logic [COEF_W-1:0] inv_i,
  input  logic [1:0]        mode_i,
  output logic [ADC_W-1:0]  mean_o,
  output logic [COEF_W-1:0] inv_o,
  output logic [1:0]        mode_o
);
  localparam logic [COEF_W-1:0] INV_ONE =
    {{(COEF_W-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};

  logic [ADC_W-1:0]  mean_q;
  logic [COEF_W-1:0] inv_q;
  logic [1:0]        mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_q <= '0;
      inv_q  <= INV_ONE;
      mode_q <= 2'b11;
    end else if (we_i) begin
      mean_q <= mean_i;
      inv_q  <= inv_i;
      mode_q <= mode_i;
    end
  end

  assign mean_o = mean_q;
  assign inv_o  = inv_q;
  assign mode_o = mode_q;
endmodule

module center_scale_mc #(
  parameter int ADC_W     = 21,
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 12,
  parameter int OUT_W     = 32
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic signed [ADC_W-1:0] x_adc,
  input  logic [CH_W-1:0]         ch_i,
  input  logic                    srdyi,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic signed [ADC_W-1:0] cfg_mean,
  input  logic [COEF_W-1:0]       cfg_invstd,
  input  logic [1:0]              cfg_mode,
  input  logic                    sat_clr,
  output logic signed [OUT_W-1:0] x_centScale,
  output logic [CH_W-1:0]         ch_o,
  output logic                    srdyo_o,
  output logic                    sat_o,
  output logic                    err_o
);
  localparam int STAGES = 3;
  localparam int DW = ADC_W + 1;
  localparam int PW = ADC_W + COEF_W + 2;
  localparam int WW = ((PW > OUT_W) ? PW : OUT_W) + 1;
  localparam logic signed [PW-1:0] HALF =
    {{(PW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [WW-1:0] OMAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] OMIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [NCH-1:0][ADC_W-1:0]  mean_a;
  logic [NCH-1:0][COEF_W-1:0] inv_a;
  logic [NCH-1:0][1:0]        mode_a;

  logic smp_ok, cfg_ok, smp_vld;
  assign smp_ok  = {{(32-CH_W){1'b0}}, ch_i}   < 32'(NCH);
  assign cfg_ok  = {{(32-CH_W){1'b0}}, cfg_ch} < 32'(NCH);
  assign smp_vld = srdyi && smp_ok;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    center_scale_mc_coef #(.ADC_W(ADC_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_coef (
      .clk    (clk),
      .rst_n  (GlobalReset),
      .we_i   (cfg_we && (cfg_ch == CH_W'(c))),
      .mean_i (cfg_mean),
      .inv_i  (cfg_invstd),
      .mode_i (cfg_mode),
      .mean_o (mean_a[c]),
      .inv_o  (inv_a[c]),
      .mode_o (mode_a[c])
    );
  end

  logic [ADC_W-1:0]  sel_mean;
  logic [COEF_W-1:0] sel_inv;
  logic [1:0]        sel_mode;

  always_comb begin
    sel_mean = '0;
    sel_inv  = '0;
    sel_mode = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_i == CH_W'(c)) begin
        sel_mean = mean_a[c];
        sel_inv  = inv_a[c];
        sel_mode = mode_a[c];
      end
    end
  end

  logic [STAGES:1]          vld_q;
  logic signed [DW-1:0]     d1_d, d1_q;
  logic [COEF_W-1:0]        inv1_q;
  logic                     scl1_q;
  logic [CH_W-1:0]          ch1_q, ch2_q, cho_q;
  logic signed [PW-1:0]     p2_d, p2_q, r3;
  logic signed [COEF_W:0]   inv1_s;
  logic signed [WW-1:0]     rw;
  logic                     clamp_hi, clamp_lo;
  logic signed [OUT_W-1:0]  out_d, out_q;
  logic                     sat_d, sat_q, err_d, err_q;

  // mode[0] selects centering, mode[1] selects scaling
  assign d1_d = sel_mode[0] ? (DW'(x_adc) - DW'($signed(sel_mean))) : DW'(x_adc);

  // unscaled modes use a unit multiplier so stage 3 rounding is shared
  assign inv1_s = $signed({1'b0, inv1_q});
  assign p2_d   = scl1_q ? (PW'(d1_q) * PW'(inv1_s)) : (PW'(d1_q) <<< COEF_FRAC);

  assign r3       = (p2_q + HALF) >>> COEF_FRAC;
  assign rw       = WW'(r3);
  assign clamp_hi = rw > OMAX;
  assign clamp_lo = rw < OMIN;
  assign out_d    = clamp_hi ? OMAX[OUT_W-1:0] : clamp_lo ? OMIN[OUT_W-1:0] : rw[OUT_W-1:0];

  assign sat_d = (sat_q && !sat_clr) || (vld_q[2] && (clamp_hi || clamp_lo));
  assign err_d = (err_q && !sat_clr) || (srdyi && !smp_ok) || (cfg_we && !cfg_ok);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      vld_q  <= '0;
      d1_q   <= '0;
      inv1_q <= '0;
      scl1_q <= 1'b0;
      ch1_q  <= '0;
      p2_q   <= '0;
      ch2_q  <= '0;
      out_q  <= '0;
      cho_q  <= '0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= {vld_q[STAGES-1:1], smp_vld};
      if (smp_vld) begin
        d1_q   <= d1_d;
        inv1_q <= sel_inv;
        scl1_q <= sel_mode[1];
        ch1_q  <= ch_i;
      end
      if (vld_q[1]) begin
        p2_q  <= p2_d;
        ch2_q <= ch1_q;
      end
      if (vld_q[2]) begin
        out_q <= out_d;
        cho_q <= ch2_q;
      end
      sat_q <= sat_d;
      err_q <= err_d;
    end
  end

  assign x_centScale = out_q;
  assign ch_o        = cho_q;
  assign srdyo_o     = vld_q[STAGES];
  assign sat_o       = sat_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_center_scale_mc.sv
// Bench for center_scale_mc: two instances (4ch/32-bit and 3ch/16-bit out) checked each
// cycle against an arithmetic model, plus literal expectations from hand calculation.

module tb_center_scale_mc;
  logic clk = 1'b0;
  logic GlobalReset = 1'b0;
  logic signed [20:0] x_adc = '0;
  logic [1:0] ch_i = '0;
  logic srdyi = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic signed [20:0] cfg_mean = '0;
  logic [15:0] cfg_invstd = '0;
  logic [1:0] cfg_mode = '0;
  logic sat_clr = 1'b0;

  logic signed [31:0] xa;
  logic [1:0] cha;
  logic srdyo_a, sat_a, err_a;
  logic signed [15:0] xb;
  logic [1:0] chb;
  logic srdyo_b, sat_b, err_b;

  always #5 clk = ~clk;

  center_scale_mc #(.NCH(4), .OUT_W(32)) dut_a (
    .clk(clk), .GlobalReset(GlobalReset), .x_adc(x_adc), .ch_i(ch_i), .srdyi(srdyi),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean), .cfg_invstd(cfg_invstd),
    .cfg_mode(cfg_mode), .sat_clr(sat_clr), .x_centScale(xa), .ch_o(cha),
    .srdyo_o(srdyo_a), .sat_o(sat_a), .err_o(err_a));

  center_scale_mc #(.NCH(3), .OUT_W(16)) dut_b (
    .clk(clk), .GlobalReset(GlobalReset), .x_adc(x_adc), .ch_i(ch_i), .srdyi(srdyi),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean), .cfg_invstd(cfg_invstd),
    .cfg_mode(cfg_mode), .sat_clr(sat_clr), .x_centScale(xb), .ch_o(chb),
    .srdyo_o(srdyo_b), .sat_o(sat_b), .err_o(err_b));

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    longint v;
    int     ch;
    bit     hl;
    longint lit;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  longint m_mean[4];
  longint m_inv[4];
  int     m_mode[4];
  longint la_v, lb_v;
  int     la_ch, lb_ch;

  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // z = round_half_up((x - mean) * inv / 4096), clamped to outw signed bits
  function automatic longint mdl(input longint x, input longint mean, input longint inv,
                                 input int mode, input int outw);
    longint d, p, r, mx;
    d  = (mode % 2 == 1) ? x - mean : x;
    p  = (mode >= 2) ? d * inv : d * 4096;
    r  = (p + 2048) >>> 12;
    mx = (longint'(1) <<< (outw - 1)) - 1;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
    return r;
  endfunction

  function automatic void mreset();
    for (int c = 0; c < 4; c++) begin
      m_mean[c] = 0; m_inv[c] = 4096; m_mode[c] = 3;
    end
    qa.delete(); qb.delete();
    la_v = 0; lb_v = 0; la_ch = 0; lb_ch = 0;
  endfunction

  bit p_s, p_we, p_clr, p_hl;
  int p_ch, p_cch, p_mode;
  longint p_x, p_mean, p_inv, p_lit;

  task automatic go();
    @(posedge clk); #1;
    srdyi = p_s; ch_i = 2'(p_ch); x_adc = 21'(p_x);
    cfg_we = p_we; cfg_ch = 2'(p_cch); cfg_mean = 21'(p_mean);
    cfg_invstd = 16'(p_inv); cfg_mode = 2'(p_mode); sat_clr = p_clr;
    if (p_s) begin
      qa.push_back('{cyc + 3, mdl(p_x, m_mean[p_ch], m_inv[p_ch], m_mode[p_ch], 32),
                     p_ch, p_hl, p_lit});
      if (p_ch < 3)
        qb.push_back('{cyc + 3, mdl(p_x, m_mean[p_ch], m_inv[p_ch], m_mode[p_ch], 16),
                       p_ch, 1'b0, 0});
    end
    if (p_we) begin
      m_mean[p_cch] = p_mean; m_inv[p_cch] = p_inv; m_mode[p_cch] = p_mode;
    end
    p_s = 0; p_we = 0; p_clr = 0; p_hl = 0;
  endtask

  task automatic set_smp(input int ch, input longint x, input bit hl, input longint lit);
    p_s = 1; p_ch = ch; p_x = x; p_hl = hl; p_lit = lit;
  endtask

  task automatic set_cfg(input int ch, input longint mean, input longint inv, input int mode);
    p_we = 1; p_cch = ch; p_mean = mean; p_inv = inv; p_mode = mode;
  endtask

  task automatic smp(input int ch, input longint x, input longint lit);
    set_smp(ch, x, 1'b1, lit); go();
  endtask

  task automatic cfg(input int ch, input longint mean, input longint inv, input int mode);
    set_cfg(ch, mean, inv, mode); go();
  endtask

  task automatic idle(input int n);
    repeat (n) go();
  endtask

  bit chk_on = 1'b0;
  always @(negedge clk) if (chk_on) begin
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("a_srdyo", srdyo_a, 1);
      chk("a_z", xa, qa[0].v);
      chk("a_ch", cha, qa[0].ch);
      if (qa[0].hl) chk("a_z_lit", xa, qa[0].lit);
      la_v = qa[0].v; la_ch = qa[0].ch;
      void'(qa.pop_front());
    end else begin
      chk("a_srdyo_idle", srdyo_a, 0);
      chk("a_z_hold", xa, la_v);
      chk("a_ch_hold", cha, la_ch);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("b_srdyo", srdyo_b, 1);
      chk("b_z", xb, qb[0].v);
      chk("b_ch", chb, qb[0].ch);
      lb_v = qb[0].v; lb_ch = qb[0].ch;
      void'(qb.pop_front());
    end else begin
      chk("b_srdyo_idle", srdyo_b, 0);
      chk("b_z_hold", xb, lb_v);
    end
  end

  initial begin
    p_s = 0; p_we = 0; p_clr = 0; p_hl = 0;
    mreset();
    // reset held while a sample is presented
    srdyi = 1'b1; x_adc = 21'sd5;
    @(posedge clk); chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_z", xa, 0);
    chk("rst_srdyo", srdyo_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_err", err_a, 0);
    @(posedge clk); #1;
    srdyi = 1'b0; GlobalReset = 1'b1;

    smp(0, 5, 5);
    idle(4);

    // scaling and round-half-up
    cfg(0, 1000, 2048, 3);
    smp(0, 3000, 1000);
    smp(0, 1001, 1);
    smp(0, 999, 0);
    idle(4);

    // modes 00/01/10/11, each mode write lands with a sample still using the previous one
    cfg(1, 100, 8192, 0);
    set_smp(1, 300, 1'b1, 300); set_cfg(1, 100, 8192, 1); go();
    set_smp(1, 300, 1'b1, 200); set_cfg(1, 100, 8192, 2); go();
    set_smp(1, 300, 1'b1, 600); set_cfg(1, 100, 8192, 3); go();
    smp(1, 300, 400);
    idle(4);

    // interleaved channels
    cfg(0, 10, 4096, 3);
    cfg(1, -10, 4096, 3);
    cfg(2, 0, 4096, 3);
    cfg(3, 0, 4096, 3);
    smp(0, 50, 40);
    smp(1, 50, 60);
    smp(2, 50, 50);
    smp(3, 50, 50);
    idle(4);
    chk("b_err_ch3", err_b, 1);
    chk("a_err_clean", err_a, 0);

    // config/sample collision
    set_smp(2, 600, 1'b1, 600); set_cfg(2, 500, 4096, 3); go();
    smp(2, 600, 100);
    idle(4);

    // reset mid-flight: in-flight samples vanish, coefficients return to defaults
    smp(2, 123, 0);
    smp(1, 77, 0);
    @(posedge clk); #1;
    srdyi = 1'b0; cfg_we = 1'b0; sat_clr = 1'b0;
    #2 GlobalReset = 1'b0; mreset();
    @(posedge clk); #1 GlobalReset = 1'b1;
    idle(4);
    chk("mrst_err", err_b, 0);
    smp(2, 600, 600);
    idle(4);

    // saturation in the 16-bit instance
    cfg(0, -1048576, 4096, 3);
    smp(0, 1048575, 2097151);
    idle(4);
    chk("b_sat_pos_z", xb, 32767);
    chk("b_sat_set", sat_b, 1);
    chk("a_sat_clean", sat_a, 0);
    cfg(1, 1048575, 4096, 3);
    smp(1, -1048576, -2097151);
    idle(4);
    chk("b_sat_neg_z", xb, -32768);

    // out-of-range channel sample, then clear
    smp(3, 7, 7);
    idle(4);
    chk("b_err_set", err_b, 1);
    p_clr = 1; go();
    idle(1);
    chk("b_sat_clr", sat_b, 0);
    chk("b_err_clr", err_b, 0);

    // set beats clear when they coincide
    set_smp(3, 9, 1'b1, 9); p_clr = 1; go();
    idle(2);
    chk("b_err_set_wins", err_b, 1);
    p_clr = 1; go();
    cfg(3, 0, 4096, 3);
    idle(1);
    chk("b_err_cfg", err_b, 1);
    p_clr = 1; go();
    smp(0, 1048575, 2097151);
    idle(1);
    p_clr = 1; go();
    idle(2);
    chk("b_sat_set_wins", sat_b, 1);
    chk("a_err_final", err_a, 0);

    idle(2);
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
